// File: rtl/mdll_pb_sel_ctl_if.sv
// Code-request handshake and thermometer select bus between the MDLL loop and the blender driver.
interface mdll_pb_sel_ctl_if #(
  parameter int N_PB   = 4,
  parameter int N_FRAC = 3
);
  logic                     en;
  logic [N_PB+N_FRAC-1:0]   code_in;
  logic                     code_req;
  logic                     code_ack;
  logic                     busy;
  logic [2**N_PB-1:0]       sel_thm;
  logic [N_PB:0]            sel_cnt;

  modport master (
    output en, code_in, code_req,
    input  code_ack, busy, sel_thm, sel_cnt
  );

  modport slave (
    input  en, code_in, code_req,
    output code_ack, busy, sel_thm, sel_cnt
  );
endinterface

// File: rtl/mdll_pb_sel_ctl.sv
// Phase-blender select driver: ramps a thermometer select bus one step per clock toward code k.
// Optional sigma-delta dither of the fractional code bits is enabled by defining MDLL_PB_DITHER_EN.
module mdll_pb_sel_ctl #(
  parameter int N_PB   = 4,
  parameter int N_FRAC = 3
) (
  input logic               clk,
  input logic               rst,
  mdll_pb_sel_ctl_if.slave  pb
);
  localparam int THM_W = 2**N_PB;
  localparam int CNT_W = N_PB + 1;

  typedef enum logic {IDLE, RAMP} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   k_q;
  logic [CNT_W-1:0]   k_new;
  logic [THM_W-1:0]   thm_q;
  logic               ack_q;
  logic               busy_q;

  function automatic logic [THM_W-1:0] thermo(input logic [CNT_W-1:0] n);
    logic [THM_W-1:0] t;
    for (int i = 0; i < THM_W; i++) t[i] = (CNT_W'(i) < n);
    return t;
  endfunction

  assign k_new = {1'b0, pb.code_in[N_PB+N_FRAC-1:N_FRAC]};

`ifdef MDLL_PB_DITHER_EN
  logic [N_FRAC-1:0]  acc_q;
  logic [N_FRAC-1:0]  f_q;
  logic [N_FRAC:0]    sum_d;

  assign sum_d = {1'b0, acc_q} + {1'b0, f_q};
`else
  logic unused_frac;
  assign unused_frac = ^pb.code_in[N_FRAC-1:0];
`endif

  // In RAMP cnt_q never equals k_q, so the step direction is always defined.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == RAMP) begin
      cnt_d = (k_q > cnt_q) ? cnt_q + 1'b1 : cnt_q - 1'b1;
    end
`ifdef MDLL_PB_DITHER_EN
    else begin
      cnt_d = k_q + CNT_W'(sum_d[N_FRAC]);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      k_q     <= '0;
      thm_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MDLL_PB_DITHER_EN
      acc_q   <= '0;
      f_q     <= '0;
`endif
    end else if (!pb.en) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pb.code_req) begin
            k_q   <= k_new;
            ack_q <= 1'b1;
`ifdef MDLL_PB_DITHER_EN
            acc_q <= '0;
            f_q   <= pb.code_in[N_FRAC-1:0];
`endif
            if (k_new != cnt_q) begin
              state_q <= RAMP;
              busy_q  <= 1'b1;
            end
          end else begin
`ifdef MDLL_PB_DITHER_EN
            // Settled cnt is k or k+1, so dithering toggles at most one select bit.
            acc_q <= sum_d[N_FRAC-1:0];
            cnt_q <= cnt_d;
            thm_q <= thermo(cnt_d);
`endif
          end
        end
        RAMP: begin
          cnt_q <= cnt_d;
          thm_q <= thermo(cnt_d);
          if (cnt_d == k_q) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pb.sel_thm  = thm_q;
  assign pb.sel_cnt  = cnt_q;
  assign pb.busy     = busy_q;
  assign pb.code_ack = ack_q;
endmodule

// File: tb/tb_mdll_pb_sel_ctl.sv
// Scoreboard bench for mdll_pb_sel_ctl: a per-edge behavioural model queues expectations, a monitor checks them.
module tb_mdll_pb_sel_ctl;
  localparam int N_PB   = 4;
  localparam int N_FRAC = 3;
  localparam int FMOD   = 1 << N_FRAC;
`ifdef MDLL_PB_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  mdll_pb_sel_ctl_if #(.N_PB(N_PB), .N_FRAC(N_FRAC)) bus ();

  mdll_pb_sel_ctl #(.N_PB(N_PB), .N_FRAC(N_FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .pb  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int busy;
    int ack;
    int was_rst;
  } exp_t;

  exp_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: effective count, target, fraction, accumulator.
  int m_cnt = 0, m_k = 0, m_f = 0, m_acc = 0;
  int m_busy = 0, m_ack = 0;

  function automatic void check(string nm, int act, int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endfunction

  task automatic step(input bit r, input bit e, input bit q, input int k, input int f);
    @(negedge clk);
    rst          = r;
    bus.en       = e;
    bus.code_req = q;
    bus.code_in  = (N_PB+N_FRAC)'(k * FMOD + f);
    if (r) begin
      m_cnt = 0; m_k = 0; m_f = 0; m_acc = 0; m_busy = 0; m_ack = 0;
    end else if (!e) begin
      m_ack = 0;
    end else if (m_busy != 0) begin
      m_ack = 0;
      m_cnt = m_cnt + ((m_k > m_cnt) ? 1 : -1);
      if (m_cnt == m_k) m_busy = 0;
    end else if (q) begin
      m_k = k; m_f = f; m_acc = 0; m_ack = 1;
      m_busy = (m_k != m_cnt) ? 1 : 0;
    end else begin
      m_ack = 0;
      if (DITHER) begin
        m_acc = m_acc + m_f;
        m_cnt = m_k + m_acc / FMOD;
        m_acc = m_acc % FMOD;
      end
    end
    sbq.push_back('{m_cnt, m_busy, m_ack, int'(r)});
  endtask

  task automatic xfer(input int k, input int f);
    int g = 0;
    do begin
      step(1'b0, 1'b1, 1'b1, k, f);
      g++;
    end while (m_ack == 0 && g < 300);
    if (m_ack == 0) check("xfer_ack_timeout", 0, 1);
    step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  task automatic settle(input int extra);
    int g = 0;
    while (m_busy != 0 && g < 100) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      g++;
    end
    repeat (extra) step(1'b0, 1'b1, 1'b0, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    int   prev_pop = 0;
    bit   have_prev = 1'b0;
    int   d;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("sel_cnt",  int'(bus.sel_cnt),  e.cnt);
        check("sel_thm",  int'(bus.sel_thm),  (1 << e.cnt) - 1);
        check("busy",     int'(bus.busy),     e.busy);
        check("code_ack", int'(bus.code_ack), e.ack);
        d = $countones(bus.sel_thm) - prev_pop;
        if (have_prev && e.was_rst == 0) check("one_bit_step", int'(d <= 1 && d >= -1), 1);
        prev_pop  = $countones(bus.sel_thm);
        have_prev = 1'b1;
      end
    end
  end

  initial begin : stim
    int g;
    bit r, e;
    int k, f;
    rst = 1'b1; bus.en = 1'b0; bus.code_req = 1'b0; bus.code_in = '0;

    repeat (2) step(1'b1, 1'b0, 1'b0, 0, 0);

    xfer(5, 0);
    settle(2);
    xfer(2, 0);
    settle(2);
    xfer(2, 4);
    settle(8);

    // Request for 9 raised right after the ramp toward 5 starts.
    xfer(5, 0);
    xfer(9, 0);
    settle(2);

    // Freeze mid-ramp at cnt=3.
    step(1'b1, 1'b1, 1'b0, 0, 0);
    xfer(7, 0);
    g = 0;
    while (m_cnt != 3 && g < 20) begin
      step(1'b0, 1'b1, 1'b0, 0, 0);
      g++;
    end
    repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
    settle(2);

    // Reset mid-ramp.
    xfer(12, 0);
    repeat (3) step(1'b0, 1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b1, 1'b0, 0, 0);
    repeat (2) step(1'b0, 1'b1, 1'b0, 0, 0);

    xfer(15, 7);
    settle(10);

    for (int t = 0; t < 60; t++) begin
      k = $urandom_range(0, 15);
      f = $urandom_range(0, 7);
      g = 0;
      do begin
        r = ($urandom_range(0, 199) == 0);
        e = ($urandom_range(0, 7) != 0);
        step(r, e, 1'b1, k, f);
        g++;
      end while (m_ack == 0 && g < 400);
      repeat ($urandom_range(0, 20)) step(1'b0, ($urandom_range(0, 7) != 0), 1'b0, 0, 0);
    end

    g = 0;
    while (sbq.size() > 0 && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (sbq.size() > 0) check("scoreboard_drain", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
